if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC, issues requests to a variable-latency instruction memory, and presents one instruction per cycle, with its PC+4, to the IF/ID pipeline register.
- Handles hazard stalls from the hazard unit, branch/jump redirects resolved in ID/EX, interrupts and exceptions.
- When IF_valid=0 the IF/ID register latches a NOP bubble, since IF_Instruction is then 0.

---
 rtl/if_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS instruction-fetch stage with variable-latency imem
//
// Purpose: owns the PC, issues one outstanding request at a time to the
// instruction memory, and presents one instruction per cycle (with its PC+4)
// to the IF/ID register. Handles stalls, branch/jump redirects, interrupts and
// exceptions.
//
// Ports:
//   sysclk, reset            clock and synchronous active-high reset
//   PC_Write                 1 = advance, 0 = stall and hold the presented word
//   redirect/redirect_target taken branch/jump and its target (bits [1:0] ignored)
//   irq, exception           interrupt (masked in kernel mode) and ID exception
//   imem_req/imem_addr       request to instruction memory, held until ack
//   imem_ack/imem_rdata      response for the outstanding request
//   IF_Instruction           instruction to IF/ID (0 when IF_valid=0)
//   IF_PC_plus_4             address of the presented instruction + 4
//   IF_valid                 IF_Instruction is a real instruction this cycle
//   PC                       current fetch address

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        irq,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC_plus_4,
  output logic        IF_valid,
  output logic [31:0] PC
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] pc_plus_4;

  logic        irq_take;
  logic        event_hit;
  logic [31:0] event_target;

  assign pc_plus_4 = pc_q + 32'd4;
  assign PC        = pc_q;

  // Interrupts are masked while executing kernel code (PC[31]=1); exception
  // and redirect are never masked. Priority: exception > irq > redirect.
  assign irq_take  = irq && !pc_q[31];
  assign event_hit = exception || irq_take || redirect;

  always_comb begin
    event_target = redirect_target & ~32'd3;
    if (exception) begin
      event_target = EXC_VECTOR;
    end else if (irq_take) begin
      event_target = IRQ_VECTOR;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= 32'd0;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_d         = hold_q;
    pend_d         = pend_q;
    imem_req       = 1'b0;
    imem_addr      = pc_q;
    IF_valid       = 1'b0;
    IF_Instruction = 32'd0;
    IF_PC_plus_4   = pc_plus_4;

    if (reset) begin
      // Memory shares this reset; any in-flight request is abandoned.
      IF_PC_plus_4 = 32'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            if (event_hit) begin
              // Fetched word belongs to the wrong path: drop it.
              pc_d = event_target;
            end else begin
              IF_valid       = 1'b1;
              IF_Instruction = imem_rdata;
              if (PC_Write) begin
                pc_d = pc_plus_4;
              end else begin
                hold_d  = imem_rdata;
                state_d = S_HOLD;
              end
            end
          end else if (event_hit) begin
            // Request cannot be withdrawn; wait for its ack and discard it.
            pend_d  = event_target;
            state_d = S_DISCARD;
          end
        end

        S_HOLD: begin
          if (event_hit) begin
            pc_d    = event_target;
            state_d = S_FETCH;
          end else begin
            IF_valid       = 1'b1;
            IF_Instruction = hold_q;
            if (PC_Write) begin
              pc_d    = pc_plus_4;
              state_d = S_FETCH;
            end
          end
        end

        S_DISCARD: begin
          imem_req = 1'b1;
          if (event_hit) begin
            pend_d = event_target;
          end
          if (imem_ack) begin
            // A same-cycle event supersedes the latched target.
            pc_d    = event_hit ? event_target : pend_q;
            state_d = S_FETCH;
          end
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        sysclk;
  logic        reset;
  logic        PC_Write;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        irq;
  logic        exception;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC_plus_4;
  logic        IF_valid;
  logic [31:0] PC;

  int          total;
  int          bad;
  int          lat;
  int          wcnt;
  logic [31:0] special_addr;
  logic [31:0] special_word;
  logic [31:0] a;

  if_fetch_unit dut (
    .sysclk          (sysclk),
    .reset           (reset),
    .PC_Write        (PC_Write),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .irq             (irq),
    .exception       (exception),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .IF_Instruction  (IF_Instruction),
    .IF_PC_plus_4    (IF_PC_plus_4),
    .IF_valid        (IF_valid),
    .PC              (PC)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Memory model: ack after lat cycles of a held request (lat=1 -> same cycle).
  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return addr ^ 32'h5A5A_5A5A;
  endfunction

  assign imem_ack   = imem_req && ((wcnt + 1) >= lat);
  assign imem_rdata = (imem_addr == special_addr) ? special_word : word_of(imem_addr);

  always @(posedge sysclk) begin
    if (reset || !imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0; wcnt = 0; lat = 1;
    reset = 1'b1; PC_Write = 1'b1; redirect = 1'b0; redirect_target = 32'd0;
    irq = 1'b0; exception = 1'b0;
    special_addr = 32'h0000_0001; special_word = 32'd0;

    // Reset state
    repeat (2) tick();
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(IF_valid), 32'd0);
    chk("rst_inst",  IF_Instruction, 32'd0);
    chk("rst_pc4",   IF_PC_plus_4, 32'd0);
    chk("rst_pc",    PC, 32'h8000_0000);

    // Single-cycle memory, back-to-back issue
    for (int i = 0; i < 3; i++) begin
      tick(); reset = 1'b0; #1;
      a = 32'h8000_0000 + 32'(4 * i);
      chk("seq_addr",  imem_addr, a);
      chk("seq_pc4",   IF_PC_plus_4, a + 32'd4);
      chk("seq_valid", 32'(IF_valid), 32'd1);
      chk("seq_inst",  IF_Instruction, word_of(a));
    end

    // 3-cycle latency
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick(); lat = 3; #1;
        a = 32'h8000_000C + 32'(4 * k);
        chk("lat_addr",  imem_addr, a);
        chk("lat_req",   32'(imem_req), 32'd1);
        chk("lat_valid", 32'(IF_valid), 32'(c == 2));
        if (c == 2) chk("lat_inst", IF_Instruction, word_of(a));
      end
    end

    // Stall: HOLD on 8C010004
    tick(); lat = 1; special_addr = 32'h8000_0014; special_word = 32'h8C01_0004; PC_Write = 1'b0; #1;
    chk("st_valid", 32'(IF_valid), 32'd1);
    chk("st_inst",  IF_Instruction, 32'h8C01_0004);
    for (int h = 0; h < 4; h++) begin
      tick(); PC_Write = (h == 3); #1;
      chk("hold_req",   32'(imem_req), 32'd0);
      chk("hold_valid", 32'(IF_valid), 32'd1);
      chk("hold_inst",  IF_Instruction, 32'h8C01_0004);
      chk("hold_pc4",   IF_PC_plus_4, 32'h8000_0018);
    end

    // Redirect while a 3-cycle fetch is outstanding, then overwrite the target
    tick(); lat = 3; redirect = 1'b1; redirect_target = 32'h0050_0000; #1;
    chk("rel_addr",  imem_addr, 32'h8000_0018);
    chk("rd_valid0", 32'(IF_valid), 32'd0);
    tick(); redirect_target = 32'h0040_0010; #1;
    chk("disc_addr",  imem_addr, 32'h8000_0018);
    chk("disc_req",   32'(imem_req), 32'd1);
    tick(); redirect = 1'b0; #1;
    chk("disc_ack",   32'(imem_ack), 32'd1);
    chk("disc_valid", 32'(IF_valid), 32'd0);
    chk("disc_inst",  IF_Instruction, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      chk("tgt_addr",  imem_addr, 32'h0040_0010);
      chk("tgt_valid", 32'(IF_valid), 32'(c == 2));
      if (c == 2) chk("tgt_inst", IF_Instruction, word_of(32'h0040_0010));
    end

    // irq in user mode, then masked in kernel mode
    for (int i = 0; i < 3; i++) begin
      tick(); lat = 1; #1;
      chk("usr_addr", imem_addr, 32'h0040_0014 + 32'(4 * i));
    end
    tick(); irq = 1'b1; #1;
    chk("irq_addr",  imem_addr, 32'h0040_0020);
    chk("irq_valid", 32'(IF_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("kirq_addr",  imem_addr, 32'h8000_0004 + 32'(4 * i));
      chk("kirq_valid", 32'(IF_valid), 32'd1);
    end

    // exception + redirect together
    tick(); irq = 1'b0; exception = 1'b1; redirect = 1'b1; redirect_target = 32'h0040_0000; #1;
    chk("exc_addr0", imem_addr, 32'h8000_0014);
    chk("exc_valid", 32'(IF_valid), 32'd0);
    tick(); exception = 1'b0; redirect = 1'b0; #1;
    chk("exc_addr", imem_addr, 32'h8000_0008);

    // Wrap at top of address space; low target bits ignored
    tick(); redirect = 1'b1; redirect_target = 32'hFFFF_FFFF; #1;
    chk("wr_valid0", 32'(IF_valid), 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4",  IF_PC_plus_4, 32'h0000_0000);
    tick(); PC_Write = 1'b0; #1;
    chk("zero_addr", imem_addr, 32'h0000_0000);
    chk("zero_valid", 32'(IF_valid), 32'd1);

    // Reset asserted in the middle of HOLD
    tick(); #1;
    chk("h2_req",  32'(imem_req), 32'd0);
    chk("h2_inst", IF_Instruction, word_of(32'h0000_0000));
    tick(); reset = 1'b1; PC_Write = 1'b1; #1;
    chk("mr_req",   32'(imem_req), 32'd0);
    chk("mr_valid", 32'(IF_valid), 32'd0);
    tick(); #1;
    chk("mr_req2",   32'(imem_req), 32'd0);
    chk("mr_valid2", 32'(IF_valid), 32'd0);
    chk("mr_pc",     PC, 32'h8000_0000);
    tick(); reset = 1'b0; #1;
    chk("res_req",  32'(imem_req), 32'd1);
    chk("res_addr", imem_addr, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
